// File: rtl/csa_tree_pkg.sv
// Shared helpers for the pipelined carry-save compressor tree: level/row counts
// and output width. Optional final adder stage is enabled by CSA_TREE_CPA_EN.
package csa_tree_pkg;

  localparam int CSA_MIN = 3;
  localparam int CSA_MAX = 16;

  // Rows remaining after lvl 3:2 levels; each level turns every full triple into two rows.
  function automatic int csa_rows_after(int n, int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) begin
      if (r > 2) r = r - r / 3;
    end
    return r;
  endfunction

  function automatic int csa_levels(int n);
    int l;
    l = 0;
    for (int i = 0; i < CSA_MAX; i++) begin
      if (csa_rows_after(n, i) > 2) l++;
    end
    return l;
  endfunction

  function automatic int csa_w_out(int n, int csa);
    return n + $clog2(csa);
  endfunction

endpackage

// File: rtl/csa_tree_pipe_level.sv
// One combinational 3:2 reduction level: each full triple of rows becomes a
// sum row and a weight-shifted carry row; the remaining 0..2 rows pass through.
module csa_level
  import csa_tree_pkg::*;
#(
  parameter int W       = 8,
  parameter int IN_ROWS = 3
) (
  input  logic [W-1:0] rows_i [IN_ROWS],
  output logic [W-1:0] rows_o [csa_rows_after(IN_ROWS, 1)]
);

  localparam int G   = IN_ROWS / 3;
  localparam int REM = IN_ROWS % 3;

  for (genvar g = 0; g < G; g++) begin : g_fa
    logic [W-1:0] a, b, c, maj;
    assign a   = rows_i[3*g];
    assign b   = rows_i[3*g+1];
    assign c   = rows_i[3*g+2];
    assign maj = (a & b) | (a & c) | (b & c);
    assign rows_o[2*g]   = a ^ b ^ c;
    // Dropping the MSB of the shifted carry is lossless: the total fits in W bits.
    assign rows_o[2*g+1] = maj << 1;
  end

  for (genvar k = 0; k < REM; k++) begin : g_pass
    assign rows_o[2*G+k] = rows_i[3*G+k];
  end

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save tree reducing CSA operands to a sum/carry pair, one register
// per level, valid/ready streaming. Define CSA_TREE_CPA_EN for a final registered adder.
module csa_tree_pipe
  import csa_tree_pkg::*;
#(
  parameter int N     = 64,
  parameter int CSA   = 6,
  parameter int TAG_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 in_data [CSA],
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [csa_w_out(N, CSA)-1:0] out_sum,
  output logic [csa_w_out(N, CSA)-1:0] out_carry,
  output logic [TAG_W-1:0]             out_tag
);

  localparam int W_OUT = csa_w_out(N, CSA);
  localparam int L     = csa_levels(CSA);

  logic             adv;
  logic             vld_q [L];
  logic [TAG_W-1:0] tag_q [L];
  logic [W_OUT-1:0] last_sum, last_carry;

  // Whole pipeline moves in lockstep; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < L; l++) begin
        vld_q[l] <= 1'b0;
        tag_q[l] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      tag_q[0] <= in_tag;
      for (int l = 1; l < L; l++) begin
        vld_q[l] <= vld_q[l-1];
        tag_q[l] <= tag_q[l-1];
      end
    end
  end

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int R_IN  = csa_rows_after(CSA, l);
    localparam int R_OUT = csa_rows_after(CSA, l + 1);

    logic [W_OUT-1:0] rows_in [R_IN];
    logic [W_OUT-1:0] rows_d  [R_OUT];
    logic [W_OUT-1:0] rows_q  [R_OUT];

    if (l == 0) begin : g_src
      always_comb begin
        for (int r = 0; r < R_IN; r++) rows_in[r] = W_OUT'(in_data[r]);
      end
    end else begin : g_src
      always_comb begin
        for (int r = 0; r < R_IN; r++) rows_in[r] = g_lvl[l-1].rows_q[r];
      end
    end

    csa_level #(.W(W_OUT), .IN_ROWS(R_IN)) u_level (
      .rows_i(rows_in),
      .rows_o(rows_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int r = 0; r < R_OUT; r++) rows_q[r] <= '0;
      end else if (adv) begin
        for (int r = 0; r < R_OUT; r++) rows_q[r] <= rows_d[r];
      end
    end
  end

  assign last_sum   = g_lvl[L-1].rows_q[0];
  assign last_carry = g_lvl[L-1].rows_q[1];

`ifdef CSA_TREE_CPA_EN
  logic [W_OUT-1:0] cpa_sum_q;
  logic             cpa_vld_q;
  logic [TAG_W-1:0] cpa_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpa_sum_q <= '0;
      cpa_vld_q <= 1'b0;
      cpa_tag_q <= '0;
    end else if (adv) begin
      cpa_sum_q <= last_sum + last_carry;
      cpa_vld_q <= vld_q[L-1];
      cpa_tag_q <= tag_q[L-1];
    end
  end

  assign out_valid = cpa_vld_q;
  assign out_sum   = cpa_sum_q;
  assign out_carry = '0;
  assign out_tag   = cpa_tag_q;
`else
  assign out_valid = vld_q[L-1];
  assign out_sum   = last_sum;
  assign out_carry = last_carry;
  assign out_tag   = tag_q[L-1];
`endif

endmodule

// File: doc/csa_tree_pipe.md
Name: csa_tree_pipe

Overview:
- Parametrised, pipelined carry-save compressor tree.
- Reduces CSA operands of N bits each to one redundant sum/carry pair (or one final sum when the optional feature is enabled).
- One pipeline register after every 3:2 reduction level; valid/ready streaming with in-order results.
- Sits ahead of the modular reduction in the NTT butterfly/multiplier datapath. Generalises the fixed 6-input bit counter to any operand count.

Parameters:
- N, 64, operand width in bits.
- CSA, 6, number of input operands; legal range 3..16.
- TAG_W, 8, width of the sideband tag carried alongside each operation.
- W_OUT, N+$clog2(CSA), output width (localparam from package, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block accepts an operand set this cycle.
- in_data  input  [N-1:0] x [CSA-1:0]  unpacked operand array.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  W_OUT  sum row.
- out_carry  output  W_OUT  carry row, already shifted into weight position.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. On assertion, all stage valid bits, data registers, out_sum, out_carry, out_tag and out_valid clear to 0. Any in-flight operations are discarded, with no partial output.
- Levels: rows r reduce to r - floor(r/3) per level until r = 2. Level count L = csa_levels(CSA), giving CSA=3→1, 4→2, 6→3, 9→4, 13→5, 16→6.
- Row widths: operands are zero-extended to W_OUT.
  - Per bit position: s = a^b^c, cy = maj(a,b,c).
  - The carry row is shifted left 1 and truncated to W_OUT. Truncation is lossless because the total is at most CSA·(2^N−1) < 2^W_OUT.
  - Leftover rows (r mod 3) pass through unchanged to the next level.
- Invariant: (out_sum + out_carry) mod 2^W_OUT equals the exact sum of the CSA operands.
- Latency: L cycles from the in_valid&&in_ready edge to out_valid. Throughput is one operation per cycle.
- Handshake:
  - Pipeline advances only when adv = !out_valid || out_ready.
  - in_ready = adv, driven combinationally.
  - When adv=0, every stage register, including valid and tag, holds.
  - out_* stay stable while out_valid && !out_ready.
- in_data is ignored when in_valid=0. A bubble enters as valid=0, and its data registers may update.
- Simultaneous accept and drain in the same cycle is legal, with no bubble inserted.
- out_sum and out_carry are don't-care when out_valid=0, except after reset, when they are 0.

Optional Feature:
- Macro: CSA_TREE_CPA_EN.
- Defined:
  - Adds one final registered carry-propagate stage.
  - out_sum = exact total (W_OUT bits); out_carry is tied to 0.
  - Latency becomes L+1. The handshake is unchanged.
- Undefined: redundant sum/carry output at latency L.

Decomposition:
- Package csa_tree_pkg:
  - function csa_levels(int n);
  - function csa_rows_after(int n, int lvl);
  - localparam helper for W_OUT;
  - typedef for the row-array type parameterised by width.
- Sub-module csa_level:
  - one combinational reduction level (IN_ROWS → OUT_ROWS, width W);
  - instantiated L times in a generate loop, with registers in the parent.

Test Plan:
1. N=64, CSA=6, inputs {1,2,3,4,5,6}, out_ready=1 → out_valid on cycle 3 after acceptance; out_sum+out_carry=21; tag returned.
2. All operands 2^64−1 → out_sum+out_carry = 0x5_FFFF_FFFF_FFFF_FFFA (67-bit) with no truncation loss.
3. Stream 10 random sets back-to-back, out_ready=1 → 10 results on consecutive cycles, in order, sums matching a golden model.
4. Pipeline full, out_ready=0 for 4 cycles → in_ready=0 throughout; outputs stable; no loss or duplication after out_ready rises.
5. Deassert rst_n with 3 ops in flight → out_valid=0 immediately; after release, the next op yields the correct result with no stale output.
6. CSA=3 and CSA=16 builds, each with and without CSA_TREE_CPA_EN → latency 1/2 and 6/7; out_carry=0 when the feature is on.
